// File: rtl/decode_stage_p.sv
// decode_stage_p: RV32I decode, register file with WB bypass, load-use detection and registered ID/EX stage.
module decode_stage_p #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    output logic            hazard_stall,
    output logic            out_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [3:0]      alu_op,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            alu_src,
    output logic            branch,
    output logic            jump,
    output logic            jalr,
    output logic            illegal
);
    localparam int RW = $clog2(NREGS);
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4, XOR = 4'd5,
                           SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9, PASSB = 4'd10;
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            reg_write, mem_read, mem_write, alu_src, branch, jump, jalr, illegal;
    } idex_t;
    logic [XLEN-1:0] r_rf [NREGS];
    idex_t r_idex, w_dec, w_bubble;
    logic [6:0] w_opc, w_f7;
    logic [4:0] w_rs1, w_rs2;
    logic [2:0] w_f3;
    logic w_op, w_opi, w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_auipc;
    logic w_use1, w_use2, w_use_rd, w_illegal, w_ok;
    logic [3:0] w_alu_arith;
    logic [31:0] w_imm32;
    logic [XLEN-1:0] w_rd1, w_rd2;
    always_comb begin
        w_opc = instr_in[6:0];
        w_f3 = instr_in[14:12];
        w_f7 = instr_in[31:25];
        w_rs1 = instr_in[19:15];
        w_rs2 = instr_in[24:20];
        w_op = w_opc == 7'b0110011;
        w_opi = w_opc == 7'b0010011;
        w_ld = w_opc == 7'b0000011;
        w_st = w_opc == 7'b0100011;
        w_br = w_opc == 7'b1100011;
        w_jal = w_opc == 7'b1101111;
        w_jalr = w_opc == 7'b1100111;
        w_lui = w_opc == 7'b0110111;
        w_auipc = w_opc == 7'b0010111;
        w_use1 = w_op | w_opi | w_ld | w_st | w_br | w_jalr;
        w_use2 = w_op | w_st | w_br;
        w_use_rd = w_op | w_opi | w_ld | w_jal | w_jalr | w_lui | w_auipc;
        w_illegal = !(w_use1 | w_jal | w_lui | w_auipc)
                  | (w_op & !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                  | ((NREGS == 16) & ((w_use1 & w_rs1[4]) | (w_use2 & w_rs2[4]) | (w_use_rd & instr_in[11])));
        w_ok = in_valid & !w_illegal;
        case (w_f3)
            3'b000:  w_alu_arith = (w_op & instr_in[30]) ? SUB : ADD;
            3'b001:  w_alu_arith = SLL;
            3'b010:  w_alu_arith = SLT;
            3'b011:  w_alu_arith = SLTU;
            3'b100:  w_alu_arith = XOR;
            3'b101:  w_alu_arith = instr_in[30] ? SRA : SRL;
            3'b110:  w_alu_arith = OR;
            default: w_alu_arith = AND;
        endcase
        w_imm32 = (w_opi | w_ld | w_jalr) ? {{20{instr_in[31]}}, instr_in[31:20]}
                : w_st ? {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]}
                : w_br ? {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0}
                : (w_lui | w_auipc) ? {instr_in[31:12], 12'b0}
                : w_jal ? {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0}
                : 32'd0;
        // Same-cycle writeback wins over the array so a just-retired result is seen here.
        w_rd1 = (w_rs1 == 5'd0) ? '0 : (wb_reg_write && wb_rd == w_rs1) ? wb_data : r_rf[w_rs1[RW-1:0]];
        w_rd2 = (w_rs2 == 5'd0) ? '0 : (wb_reg_write && wb_rd == w_rs2) ? wb_data : r_rf[w_rs2[RW-1:0]];
        hazard_stall = !flush & in_valid & ex_mem_read & (ex_rd != 5'd0)
                     & ((w_use1 & ex_rd == w_rs1) | (w_use2 & ex_rd == w_rs2));
        w_dec = '0;
        w_dec.valid = in_valid;
        w_dec.pc = pc_in;
        w_dec.rs1_data = w_use1 ? w_rd1 : '0;
        w_dec.rs2_data = w_use2 ? w_rd2 : '0;
        w_dec.imm = XLEN'($signed(w_imm32));
        w_dec.rs1 = w_use1 ? w_rs1 : 5'd0;
        w_dec.rs2 = w_use2 ? w_rs2 : 5'd0;
        w_dec.rd = instr_in[11:7];
        w_dec.funct3 = w_f3;
        w_dec.alu_op = !w_ok ? ADD : (w_op | w_opi) ? w_alu_arith : w_lui ? PASSB : w_br ? SUB : ADD;
        w_dec.reg_write = w_ok & w_use_rd;
        w_dec.mem_read = w_ok & w_ld;
        w_dec.mem_write = w_ok & w_st;
        w_dec.alu_src = w_ok & !(w_op | w_br);
        w_dec.branch = w_ok & w_br;
        w_dec.jump = w_ok & (w_jal | w_jalr);
        w_dec.jalr = w_ok & w_jalr;
        w_dec.illegal = in_valid & w_illegal;
        w_bubble = '0;
        w_bubble.pc = RESET_PC;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
            r_idex <= w_bubble;
        end else begin
            if (wb_reg_write && wb_rd != 5'd0) r_rf[wb_rd[RW-1:0]] <= wb_data;
            if (flush || (!stall && hazard_stall)) r_idex <= w_bubble;
            else if (!stall) r_idex <= w_dec;
        end
    end
    assign {out_valid, pc_out, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, alu_op,
            reg_write, mem_read, mem_write, alu_src, branch, jump, jalr, illegal} = r_idex;
endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised ID stage: RV32I instruction decode, register file, registered ID/EX pipeline register with valid tracking.
- Sits between fetch and execute.
- Adds three things: write-through bypass from writeback, load-use hazard detection, and an RV32E-style reduced register file option.
- All ID/EX outputs are registered; hazard_stall is the only combinational output.

Parameters:
- XLEN, 32: datapath width for pc, register data and imm (32 or 64; imm sign-extended to XLEN).
- NREGS, 32: architectural register count (32 or 16); register index width RW = log2(NREGS).
- RESET_PC, 0: pc_out value on reset and on flush bubble.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr_in/pc_in carry a real instruction
- instr_in  in  32  instruction from fetch
- pc_in  in  XLEN  pc of instr_in
- stall  in  1  downstream hold; ID/EX register keeps its contents
- flush  in  1  kill; ID/EX loads a bubble
- wb_reg_write  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback data
- ex_mem_read  in  1  instruction now in EX is a load
- ex_rd  in  5  destination of instruction now in EX
- hazard_stall  out  1  combinational load-use stall request to fetch/PC
- out_valid  out  1  ID/EX holds a real instruction
- pc_out  out  XLEN  registered pc
- rs1_data, rs2_data  out  XLEN  registered operands
- imm  out  XLEN  registered sign-extended immediate
- rs1, rs2, rd  out  5  registered register indices
- funct3  out  3  registered instr[14:12]
- alu_op  out  4  registered ALU operation
- reg_write, mem_read, mem_write, alu_src, branch, jump, jalr  out  1  registered control
- illegal  out  1  registered illegal-instruction flag

Behaviour:
- Reset (reset_n low, asynchronous): all register-file entries 0; all outputs 0; pc_out = RESET_PC.
- Register file: write on clk when wb_reg_write and wb_rd != 0, into entry wb_rd[RW-1:0]. Index 0 always reads 0.
- Bypass: for each source s, if wb_reg_write and wb_rd == s and s != 0, the operand is wb_data (same-cycle write-then-read). Otherwise the operand is the array value.
- Source usage:
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
  - Operand data and the rs1/rs2 outputs are forced to 0 when the source is unused.
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- OP / OP-IMM: alu_op from funct3 plus instr[30]. SUB applies to OP only; SRA/SRL are selected by instr[30] in both.
- LOAD, STORE, JAL, JALR, AUIPC: alu_op ADD. LUI: PASSB. BRANCH: SUB.
- Immediates per RV32I I/S/B/U/J formats, sign-extended to XLEN. U-type is imm[31:12]<<12.
- Illegal cases:
  - unknown opcode;
  - OP with funct7 not in {0x00, 0x20}, or 0x20 with funct3 not in {000, 101};
  - NREGS=16 and any used register field has bit 4 set.
- On illegal: illegal=1, every other control bit 0, out_valid=1.
- Load-use hazard:
  - hazard_stall = in_valid & ex_mem_read & ex_rd != 0 & ((rs1 used & ex_rd == rs1) | (rs2 used & ex_rd == rs2)).
  - It is forced to 0 while flush is high.
- ID/EX update priority per clock: flush > stall > hazard_stall > load.
  - flush: bubble (out_valid=0, all control 0, pc_out=RESET_PC, data 0).
  - stall: hold all outputs.
  - hazard_stall: bubble.
  - load: capture decode; out_valid = in_valid. If in_valid=0, control bits are 0.
- Latency: 1 cycle from instr_in to outputs.
- Reset asserted mid-stall or mid-hazard clears everything immediately; no pending state survives.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093) at pc 0x100, in_valid=1 -> next cycle: out_valid=1, rd=1, imm=5, alu_op=0, alu_src=1, reg_write=1, pc_out=0x100, rs1_data=0.
- wb_reg_write=1, wb_rd=3, wb_data=0xDEADBEEF while decoding ADD x4,x3,x3 -> rs1_data=rs2_data=0xDEADBEEF in the same decode (bypass). Also wb_rd=0 -> x0 still reads 0.
- ex_mem_read=1, ex_rd=2, decode SUB x5,x2,x1 -> hazard_stall=1 and next cycle out_valid=0. Same with SW whose rs1 = x9 != 2 and rs2 = x2 -> hazard_stall=1. LUI x2 -> hazard_stall=0.
- stall=1 for 3 cycles with changing instr_in -> outputs frozen. flush=1 together with stall=1 -> bubble, pc_out=RESET_PC.
- Opcode 0x7F -> illegal=1, reg_write=0, out_valid=1. With NREGS=16, ADD x17,x1,x2 -> illegal=1.
- BEQ offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC, branch=1, alu_op=1. JAL offset +2048 -> imm=0x800, jump=1, reg_write=1.
